display_scanner: RTL

- Time-multiplexed driver for a bank of common-cathode seven-segment digits.
- Captures a packed multi-digit hex/BCD value and walks one digit at a time at a programmable refresh rate.
- Presents the selected nibble on `bcd` to the downstream `sevensegmentdecoder`, and a one-hot digit enable to the display anodes/cathode drivers.
- Sits directly upstream of the decoder; segment patterns are not generated here.

---
 rtl/display_pkg.sv | 20 ++
 rtl/tick_gen.sv | 34 +++
 rtl/display_scanner.sv | 101 ++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants and helpers for the seven-segment display scanner.
// Contents:
//   NIBBLE_W                          - width of one displayed digit
//   DEFAULT_DIGITS / DEFAULT_PRESCALE - default scanner configuration
//   MAX_DIGITS                        - widest bank the scanner supports
//   onehot(idx)                       - one-hot digit vector (MAX_DIGITS wide; callers slice it)
package display_pkg;

  localparam int unsigned NIBBLE_W         = 4;
  localparam int unsigned DEFAULT_DIGITS   = 4;
  localparam int unsigned DEFAULT_PRESCALE = 1000;
  localparam int unsigned MAX_DIGITS       = 8;

  typedef logic [MAX_DIGITS-1:0] digit_vec_t;

  function automatic digit_vec_t onehot(input logic [2:0] idx);
    return digit_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Refresh prescaler for the display scanner.
// Counts 0..PRESCALE-1 and flags the last count so the scanner can step digits.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous active-high reset (counter to 0)
//   tick  - high while the counter sits at PRESCALE-1
module tick_gen #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a bank of common-cathode seven-segment digits.
// Holds a shadow copy of the packed digit value and lights one digit at a time,
// PRESCALE cycles per digit, presenting its nibble to the downstream decoder.
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   value      - packed digits, nibble 0 is the rightmost digit
//   load       - capture strobe for value into the shadow register
//   blank      - forces all digit enables off; scanning continues
//   bcd        - nibble of the lit digit (registered)
//   digit_en   - one-hot enable of the lit digit (registered)
//   frame_done - one-cycle pulse as the scan wraps from the last digit to digit 0
// Build option: define DISPLAY_SCANNER_LZB_EN for leading-zero blanking.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned DIGITS   = DEFAULT_DIGITS,
  parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NIBBLE_W*DIGITS-1:0]   value,
  input  logic                         load,
  input  logic                         blank,
  output logic [NIBBLE_W-1:0]          bcd,
  output logic [DIGITS-1:0]            digit_en,
  output logic                         frame_done
);

  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  logic                       tick;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [NIBBLE_W*DIGITS-1:0] shadow_q, shadow_d;
  logic [NIBBLE_W-1:0]        bcd_q, bcd_d;
  logic [DIGITS-1:0]          digit_en_q, digit_en_d;
  logic                       frame_done_q, frame_done_d;
  logic [DIGITS-1:0]          keep;
  digit_vec_t                 oh_full;
  logic                       unused_oh;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Digits whose nibble and every nibble to its left are zero are leading zeros.
  always_comb begin
    keep = '1;
`ifdef DISPLAY_SCANNER_LZB_EN
    begin
      logic nz;
      nz = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        nz      = nz | (|shadow_q[NIBBLE_W*i +: NIBBLE_W]);
        keep[i] = nz;
      end
    end
`endif
  end

  assign oh_full   = onehot(3'(idx_q));
  assign unused_oh = ^(oh_full >> DIGITS);

  always_comb begin
    idx_d        = idx_q;
    if (tick) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
    shadow_d     = load ? value : shadow_q;
    // Outputs read the pre-edge idx/shadow, giving one cycle of latency.
    bcd_d        = shadow_q[NIBBLE_W*idx_q +: NIBBLE_W];
    digit_en_d   = blank ? '0 : (oh_full[DIGITS-1:0] & keep);
    frame_done_d = tick && (idx_q == LastIdx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      bcd_q        <= '0;
      digit_en_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      bcd_q        <= bcd_d;
      digit_en_q   <= digit_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd        = bcd_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule
